// File: rtl/snake_sched.sv
// rtl/snake_sched.sv - snake body ring, step engine and head-to-tail walk streamer
module snake_sched #(
    parameter int GAME_WIDTH  = 20,
    parameter int GAME_HEIGHT = 13,
    parameter int MAX_LEN     = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       game_rst_n,
    input  logic       scan_start,
    input  logic       step_req,
    input  logic [1:0] step_dir,
    input  logic       step_grow,
    output logic       step_ack,
    output logic [4:0] snake_head_x,
    output logic [3:0] snake_head_y,
    output logic [4:0] snake_x,
    output logic [3:0] snake_y,
    output logic [1:0] snake_dir,
    output logic       snake_first,
    output logic       snake_last,
    output logic       snake_valid,
    output logic [5:0] length,
    output logic       busy,
    output logic       wall_hit,
    output logic       self_hit
);

    localparam int         PW       = $clog2(MAX_LEN);
    localparam logic [4:0] X_MAX    = 5'(GAME_WIDTH);
    localparam logic [3:0] Y_MAX    = 4'(GAME_HEIGHT);
    localparam logic [4:0] X_RST    = 5'(GAME_WIDTH / 2);
    localparam logic [3:0] Y_RST    = 4'((GAME_HEIGHT + 1) / 2);
    localparam logic [5:0] LEN_MAX  = 6'(MAX_LEN);
    localparam logic [5:0] LEN_RST  = 6'd3;
    localparam logic [1:0] DIR_LEFT = 2'd2;

    typedef enum logic {S_IDLE, S_WALK} state_t;

    function automatic logic [4:0] move_x(input logic [4:0] x, input logic [1:0] d);
        case (d)
            2'd2:    move_x = x - 5'd1;
            2'd3:    move_x = x + 5'd1;
            default: move_x = x;
        endcase
    endfunction

    function automatic logic [3:0] move_y(input logic [3:0] y, input logic [1:0] d);
        case (d)
            2'd0:    move_y = y - 4'd1;
            2'd1:    move_y = y + 4'd1;
            default: move_y = y;
        endcase
    endfunction

    state_t        state_q, state_d;
    logic [PW-1:0] hp_q, hp_d;
    logic [PW-1:0] k_q, k_d;
    logic [5:0]    len_q, len_d;
    logic [4:0]    head_x_q, head_x_d;
    logic [3:0]    head_y_q, head_y_d;
    logic [4:0]    sx_q, sx_d;
    logic [3:0]    sy_q, sy_d;
    logic [1:0]    sdir_q, sdir_d;
    logic          first_q, first_d;
    logic          last_q, last_d;
    logic          valid_q, valid_d;
    logic          wall_q, wall_d;
    logic          self_q, self_d;

    logic [1:0]    ring_q [MAX_LEN];
    logic          ring_we;
    logic [PW-1:0] ring_waddr;
    logic [1:0]    ring_wdata;

    logic          step_ok;
    logic          hits_wall;
    logic [PW-1:0] k_n;

    // A step is taken only while idle and not pre-empted by a scan request
    assign step_ok = step_req & (state_q == S_IDLE) & ~scan_start & game_rst_n;

    // Would moving the head in step_dir leave the playfield (head is always on-field)
    always_comb begin
        hits_wall = 1'b0;
        case (step_dir)
            2'd0: hits_wall = (head_y_q <= 4'd1);
            2'd1: hits_wall = (head_y_q >= Y_MAX);
            2'd2: hits_wall = (head_x_q <= 5'd1);
            2'd3: hits_wall = (head_x_q >= X_MAX);
            default: hits_wall = 1'b0;
        endcase
    end

    // Next-state: walk sequencing, step application and collision flags
    always_comb begin
        state_d    = state_q;
        hp_d       = hp_q;
        k_d        = k_q;
        len_d      = len_q;
        head_x_d   = head_x_q;
        head_y_d   = head_y_q;
        sx_d       = sx_q;
        sy_d       = sy_q;
        sdir_d     = sdir_q;
        first_d    = first_q;
        last_d     = last_q;
        valid_d    = valid_q;
        wall_d     = wall_q;
        self_d     = self_q;
        ring_we    = 1'b0;
        ring_waddr = hp_q - PW'(1);
        ring_wdata = {step_dir[1], ~step_dir[0]};
        k_n        = k_q + PW'(1);

        // Body segment (not the head itself) landing on the head tile
        if (state_q == S_WALK && k_q != '0 && sx_q == head_x_q && sy_q == head_y_q) begin
            self_d = 1'b1;
        end

        if (scan_start) begin
            state_d = S_WALK;
            k_d     = '0;
            sx_d    = head_x_q;
            sy_d    = head_y_q;
            first_d = 1'b1;
            last_d  = (len_q == 6'd1);
            sdir_d  = (len_q == 6'd1) ? 2'd0 : ring_q[hp_q];
            valid_d = 1'b1;
        end else if (state_q == S_WALK) begin
            if (last_q) begin
                state_d = S_IDLE;
                valid_d = 1'b0;
                first_d = 1'b0;
                last_d  = 1'b0;
            end else begin
                k_d     = k_n;
                sx_d    = move_x(sx_q, sdir_q);
                sy_d    = move_y(sy_q, sdir_q);
                first_d = 1'b0;
                last_d  = (6'(k_n) == len_q - 6'd1);
                sdir_d  = (6'(k_n) == len_q - 6'd1) ? 2'd0 : ring_q[hp_q + k_n];
            end
        end else if (step_ok) begin
            if (hits_wall) begin
                wall_d = 1'b1;
            end else begin
                hp_d     = hp_q - PW'(1);
                ring_we  = 1'b1;
                head_x_d = move_x(head_x_q, step_dir);
                head_y_d = move_y(head_y_q, step_dir);
                if (step_grow && len_q < LEN_MAX) begin
                    len_d = len_q + 6'd1;
                end
            end
        end
    end

    // State and output registers; game restart behaves like reset on game state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            hp_q     <= '0;
            k_q      <= '0;
            len_q    <= LEN_RST;
            head_x_q <= X_RST;
            head_y_q <= Y_RST;
            sx_q     <= '0;
            sy_q     <= '0;
            sdir_q   <= '0;
            first_q  <= 1'b0;
            last_q   <= 1'b0;
            valid_q  <= 1'b0;
            wall_q   <= 1'b0;
            self_q   <= 1'b0;
        end else if (!game_rst_n) begin
            state_q  <= S_IDLE;
            hp_q     <= '0;
            k_q      <= '0;
            len_q    <= LEN_RST;
            head_x_q <= X_RST;
            head_y_q <= Y_RST;
            sx_q     <= '0;
            sy_q     <= '0;
            sdir_q   <= '0;
            first_q  <= 1'b0;
            last_q   <= 1'b0;
            valid_q  <= 1'b0;
            wall_q   <= 1'b0;
            self_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            hp_q     <= hp_d;
            k_q      <= k_d;
            len_q    <= len_d;
            head_x_q <= head_x_d;
            head_y_q <= head_y_d;
            sx_q     <= sx_d;
            sy_q     <= sy_d;
            sdir_q   <= sdir_d;
            first_q  <= first_d;
            last_q   <= last_d;
            valid_q  <= valid_d;
            wall_q   <= wall_d;
            self_q   <= self_d;
        end
    end

    // Direction ring: every link points left so the reset body is a straight line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_LEN; i++) ring_q[i] <= DIR_LEFT;
        end else if (!game_rst_n) begin
            for (int i = 0; i < MAX_LEN; i++) ring_q[i] <= DIR_LEFT;
        end else if (ring_we) begin
            ring_q[ring_waddr] <= ring_wdata;
        end
    end

    assign step_ack     = step_ok & rst_n;
    assign snake_head_x = head_x_q;
    assign snake_head_y = head_y_q;
    assign snake_x      = sx_q;
    assign snake_y      = sy_q;
    assign snake_dir    = sdir_q;
    assign snake_first  = first_q;
    assign snake_last   = last_q;
    assign snake_valid  = valid_q;
    assign busy         = valid_q;
    assign length       = len_q;
    assign wall_hit     = wall_q;
    assign self_hit     = self_q;

endmodule

// File: tb/tb_snake_sched.sv
// tb/tb_snake_sched.sv - directed self-checking bench for snake_sched
module tb_snake_sched;

    logic       clk = 1'b0;
    logic       rst_n, game_rst_n, scan_start, step_req, step_grow;
    logic [1:0] step_dir;
    logic       step_ack;
    logic [4:0] snake_head_x, snake_x;
    logic [3:0] snake_head_y, snake_y;
    logic [1:0] snake_dir;
    logic       snake_first, snake_last, snake_valid, busy, wall_hit, self_hit;
    logic [5:0] length;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    snake_sched dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .game_rst_n   (game_rst_n),
        .scan_start   (scan_start),
        .step_req     (step_req),
        .step_dir     (step_dir),
        .step_grow    (step_grow),
        .step_ack     (step_ack),
        .snake_head_x (snake_head_x),
        .snake_head_y (snake_head_y),
        .snake_x      (snake_x),
        .snake_y      (snake_y),
        .snake_dir    (snake_dir),
        .snake_first  (snake_first),
        .snake_last   (snake_last),
        .snake_valid  (snake_valid),
        .length       (length),
        .busy         (busy),
        .wall_hit     (wall_hit),
        .self_hit     (self_hit)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_seg(input string tag, input int x, input int y, input int d,
                             input bit f, input bit l);
        logic [31:0] exp;
        exp = {17'd0, 1'b1, 1'b1, f, l, 2'(d), 5'(x), 4'(y)};
        check(tag, {17'd0, snake_valid, busy, snake_first, snake_last, snake_dir, snake_x, snake_y}, exp);
    endtask

    task automatic check_idle(input string tag);
        check(tag, {28'd0, snake_valid, busy, snake_first, snake_last}, 32'd0);
    endtask

    task automatic check_head(input string tag, input int x, input int y, input int len);
        logic [31:0] exp;
        exp = {17'd0, 5'(x), 4'(y), 6'(len)};
        check(tag, {17'd0, snake_head_x, snake_head_y, length}, exp);
    endtask

    task automatic do_step(input int d, input bit g);
        step_req  = 1'b1;
        step_dir  = 2'(d);
        step_grow = g;
        #1;
        check("step_ack", {31'd0, step_ack}, 32'd1);
        tick();
        step_req  = 1'b0;
        step_grow = 1'b0;
    endtask

    task automatic do_scan();
        scan_start = 1'b1;
        tick();
        scan_start = 1'b0;
    endtask

    task automatic game_restart();
        game_rst_n = 1'b0;
        tick();
        game_rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; game_rst_n = 1'b1; scan_start = 1'b0;
        step_req = 1'b0; step_dir = 2'd0; step_grow = 1'b0;
        tick(); tick();
        check_idle("reset_idle");
        check("reset_flags", {29'd0, step_ack, wall_hit, self_hit}, 32'd0);
        check("reset_stream", {21'd0, snake_x, snake_y, snake_dir}, 32'd0);
        check_head("reset_head", 10, 7, 3);
        rst_n = 1'b1;
        tick();

        // straight reset body
        do_scan();
        check_seg("r_seg0", 10, 7, 2, 1, 0); tick();
        check_seg("r_seg1", 9, 7, 2, 0, 0);  tick();
        check_seg("r_seg2", 8, 7, 0, 0, 1);  tick();
        check_idle("r_idle");

        // plain move right
        do_step(3, 0);
        check_head("mv_head", 11, 7, 3);
        do_scan();
        check_seg("mv_seg0", 11, 7, 2, 1, 0); tick();
        check_seg("mv_seg1", 10, 7, 2, 0, 0); tick();
        check_seg("mv_seg2", 9, 7, 0, 0, 1);  tick();
        check_idle("mv_idle");

        // game restart with step_req held: no ack while restart asserted
        game_rst_n = 1'b0; step_req = 1'b1; step_dir = 2'd3; step_grow = 1'b1;
        #1;
        check("rst_no_ack", {31'd0, step_ack}, 32'd0);
        tick();
        game_rst_n = 1'b1;
        check_head("grst_head", 10, 7, 3);
        #1;
        check("rel_ack", {31'd0, step_ack}, 32'd1);
        tick();
        step_req = 1'b0; step_grow = 1'b0;
        check_head("grow_head", 11, 7, 4);
        do_scan();
        check_seg("g_seg0", 11, 7, 2, 1, 0); tick();
        check_seg("g_seg1", 10, 7, 2, 0, 0); tick();
        check_seg("g_seg2", 9, 7, 2, 0, 0);  tick();
        check_seg("g_seg3", 8, 7, 0, 0, 1);  tick();
        check_idle("g_idle");

        // grow to saturation while bouncing up/down in place
        for (int i = 0; i < 28; i++) do_step(i % 2, 1);
        check_head("sat_head", 11, 7, 32);
        do_step(0, 1);
        check_head("sat_hold", 11, 6, 32);
        check("sat_wall", {31'd0, wall_hit}, 32'd0);

        // step held across a scan and a full 32-segment walk
        step_req = 1'b1; step_dir = 2'd2; scan_start = 1'b1;
        #1;
        check("scan_prio", {31'd0, step_ack}, 32'd0);
        tick();
        scan_start = 1'b0;
        for (int i = 0; i < 32; i++) begin
            check("walk_noack", {29'd0, snake_valid, snake_last, step_ack},
                  {29'd0, 1'b1, (i == 31), 1'b0});
            tick();
        end
        check("post_walk_ack", {30'd0, snake_valid, step_ack}, 32'd1);
        tick();
        step_req = 1'b0;
        check_head("held_step", 10, 6, 32);
        check("reverse_self", {31'd0, self_hit}, 32'd1);

        // walk up into the top border
        game_restart();
        check("grst_flags", {30'd0, wall_hit, self_hit}, 32'd0);
        check_head("grst_head2", 10, 7, 3);
        for (int i = 0; i < 6; i++) do_step(0, 0);
        check_head("top_row", 10, 1, 3);
        check("pre_wall", {31'd0, wall_hit}, 32'd0);
        do_step(0, 0);
        check("wall_set", {31'd0, wall_hit}, 32'd1);
        check_head("wall_head", 10, 1, 3);
        do_step(3, 0);
        check_head("after_wall", 11, 1, 3);
        check("wall_sticky", {31'd0, wall_hit}, 32'd1);

        // scan restart in the middle of a walk
        do_scan();
        check_seg("rs_seg0", 11, 1, 2, 1, 0); tick();
        check_seg("rs_seg1", 10, 1, 1, 0, 0);
        do_scan();
        check_seg("rs_again0", 11, 1, 2, 1, 0); tick();
        check_seg("rs_again1", 10, 1, 1, 0, 0); tick();
        check_seg("rs_again2", 10, 2, 0, 0, 1); tick();
        check_idle("rs_idle");

        // curl back onto the body
        game_restart();
        do_step(3, 1);
        do_step(3, 1);
        check_head("len5", 12, 7, 5);
        do_step(0, 0);
        do_step(2, 0);
        do_step(1, 0);
        check_head("curl_head", 11, 7, 5);
        do_scan();
        check_seg("c_seg0", 11, 7, 0, 1, 0); tick();
        check_seg("c_seg1", 11, 6, 3, 0, 0); tick();
        check_seg("c_seg2", 12, 6, 1, 0, 0); tick();
        check_seg("c_seg3", 12, 7, 2, 0, 0); tick();
        check_seg("c_seg4", 11, 7, 0, 0, 1);
        check("self_before", {31'd0, self_hit}, 32'd0);
        tick();
        check("self_set", {31'd0, self_hit}, 32'd1);
        check_idle("c_idle");

        // asynchronous reset mid-walk
        do_scan();
        check_seg("a_seg0", 11, 7, 0, 1, 0); tick();
        #2 rst_n = 1'b0;
        #1;
        check("async_clear", {29'd0, snake_valid, busy, self_hit}, 32'd0);
        check_head("async_head", 10, 7, 3);
        tick();
        rst_n = 1'b1;
        tick();
        check_idle("async_idle");
        do_scan();
        check_seg("a_r0", 10, 7, 2, 1, 0); tick();
        check_seg("a_r1", 9, 7, 2, 0, 0);  tick();
        check_seg("a_r2", 8, 7, 0, 0, 1);  tick();
        check_idle("a_ridle");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
